// File: rtl/mcu_csr_if.sv
// mcu_csr_if: CSR request/response bus between the MCU decoder (master)
// and the CSR file (slave). The response is combinational in the request cycle.
interface mcu_csr_if;
   logic        csr_valid;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_operand;
   logic        csr_wr_suppress;
   logic [31:0] csr_rdata;
   logic        csr_illegal;

   modport master (
      output csr_valid, csr_addr, csr_op, csr_operand, csr_wr_suppress,
      input  csr_rdata, csr_illegal
   );

   modport slave (
      input  csr_valid, csr_addr, csr_op, csr_operand, csr_wr_suppress,
      output csr_rdata, csr_illegal
   );
endinterface

// File: rtl/mcu_csr_unit.sv
// mcu_csr_unit: control-processor CSR file. Executes CSR read/modify/write
// requests (answered combinationally, committed on the next rising edge),
// owns trap entry / MRET state, interrupt pending, mailbox, trace control
// and an optional watchdog.
// Optional feature macro: MCU_CSR_WDOG_EN (watchdog counter, WDOG_CTRL,
// mip/mie bit16 WDIP and the wdog outputs). Undefined: WDOG/WDOG_CTRL read 0,
// writes are accepted and ignored, wdog outputs tied low.
// Custom CSR map: 0x7C0 UID, 0x7C1 CAPS, 0x7C2 WDOG, 0x7C3 WDOG_CTRL,
// 0x7C4 MAILBOX_BASE, 0x7C5 MAILBOX_STATUS, 0x7C6 TRACE_CTRL.
module mcu_csr_unit #(
   parameter logic [31:0] UID      = 32'h0000_0000,
   parameter logic [31:0] CAPS     = 32'h0000_0001,
   parameter int          NUM_MBOX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mcu_csr_if.slave            csr,
   input  logic                trap_valid,
   input  logic [31:0]         trap_cause,
   input  logic [31:0]         trap_pc,
   input  logic [31:0]         trap_tval,
   input  logic                mret_valid,
   output logic [31:0]         trap_vector,
   output logic [31:0]         mret_pc,
   input  logic                msip_i,
   input  logic                mtip_i,
   input  logic                meip_i,
   input  logic [NUM_MBOX-1:0] mbox_set,
   output logic                irq_pending,
   output logic                wdog_expire,
   output logic                wdog_rst_req,
   output logic [31:0]         mbox_base,
   output logic [7:0]          trace_ctrl
);

   localparam logic [11:0] CSR_MSTATUS        = 12'h300;
   localparam logic [11:0] CSR_MIE            = 12'h304;
   localparam logic [11:0] CSR_MTVEC          = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
   localparam logic [11:0] CSR_MEPC           = 12'h341;
   localparam logic [11:0] CSR_MCAUSE         = 12'h342;
   localparam logic [11:0] CSR_MTVAL          = 12'h343;
   localparam logic [11:0] CSR_MIP            = 12'h344;
   localparam logic [11:0] CSR_CP_UID         = 12'h7C0;
   localparam logic [11:0] CSR_CP_CAPS        = 12'h7C1;
   localparam logic [11:0] CSR_CP_WDOG        = 12'h7C2;
   localparam logic [11:0] CSR_CP_WDOG_CTRL   = 12'h7C3;
   localparam logic [11:0] CSR_CP_MBOX_BASE   = 12'h7C4;
   localparam logic [11:0] CSR_CP_MBOX_STATUS = 12'h7C5;
   localparam logic [11:0] CSR_CP_TRACE_CTRL  = 12'h7C6;

`ifdef MCU_CSR_WDOG_EN
   localparam logic [31:0] MIE_MASK = 32'h0001_0888;
`else
   localparam logic [31:0] MIE_MASK = 32'h0000_0888;
`endif

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'd0,
      CSR_OP_W    = 2'd1,
      CSR_OP_S    = 2'd2,
      CSR_OP_C    = 2'd3
   } csr_op_e;

   csr_op_e op;
   assign op = csr_op_e'(csr.csr_op);

   // Architectural state
   logic                mstatus_mie_q, mstatus_mie_d;
   logic                mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0]         mie_q, mie_d;
   logic [31:0]         mtvec_q, mtvec_d;
   logic [31:0]         mscratch_q, mscratch_d;
   logic [31:0]         mepc_q, mepc_d;
   logic [31:0]         mcause_q, mcause_d;
   logic [31:0]         mtval_q, mtval_d;
   logic [31:0]         mbox_base_q, mbox_base_d;
   logic [NUM_MBOX-1:0] mbox_stat_q, mbox_stat_d;
   logic [7:0]          trace_q, trace_d;

   // Watchdog-side read values (zero when the watchdog is not built)
   logic [31:0] wdog_rd, wdog_ctrl_rd;
   logic        wdip_rd;

   logic [31:0] mip_rd, mbox_stat_ext, old_val, wval;
   logic        addr_known, addr_ro, csr_illegal_c, wr_en;

   assign mip_rd = {15'b0, wdip_rd, 4'b0, meip_i, 3'b0, mtip_i, 3'b0, msip_i, 3'b0};

   // Read mux: old CSR value plus address decode for legality
   always_comb begin
      old_val       = '0;
      addr_known    = 1'b1;
      addr_ro       = 1'b0;
      mbox_stat_ext = '0;
      mbox_stat_ext[NUM_MBOX-1:0] = mbox_stat_q;
      case (csr.csr_addr)
         CSR_MSTATUS:        old_val = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         CSR_MIE:            old_val = mie_q;
         CSR_MTVEC:          old_val = mtvec_q;
         CSR_MSCRATCH:       old_val = mscratch_q;
         CSR_MEPC:           old_val = mepc_q;
         CSR_MCAUSE:         old_val = mcause_q;
         CSR_MTVAL:          old_val = mtval_q;
         CSR_MIP:            old_val = mip_rd;
         CSR_CP_UID:         begin old_val = UID;  addr_ro = 1'b1; end
         CSR_CP_CAPS:        begin old_val = CAPS; addr_ro = 1'b1; end
         CSR_CP_WDOG:        old_val = wdog_rd;
         CSR_CP_WDOG_CTRL:   old_val = wdog_ctrl_rd;
         CSR_CP_MBOX_BASE:   old_val = mbox_base_q;
         CSR_CP_MBOX_STATUS: old_val = mbox_stat_ext;
         CSR_CP_TRACE_CTRL:  old_val = {24'b0, trace_q};
         default:            addr_known = 1'b0;
      endcase
   end

   // Write value from the read-modify-write op
   always_comb begin
      wval = old_val;
      case (op)
         CSR_OP_W: wval = csr.csr_operand;
         CSR_OP_S: wval = old_val | csr.csr_operand;
         CSR_OP_C: wval = old_val & ~csr.csr_operand;
         default:  wval = old_val;
      endcase
   end

   // A suppressed S/C is a pure read, so it is not an illegal write to a read-only CSR
   assign csr_illegal_c = !addr_known ||
                          (addr_ro && (op != CSR_OP_NONE) && !csr.csr_wr_suppress);
   assign wr_en = csr.csr_valid && (op != CSR_OP_NONE) && !csr.csr_wr_suppress &&
                  !csr_illegal_c && !trap_valid;

   assign csr.csr_rdata   = old_val;
   assign csr.csr_illegal = csr_illegal_c;

   // Next state: trap beats MRET beats a CSR write; mailbox sets beat W1C clears
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mbox_base_d    = mbox_base_q;
      mbox_stat_d    = mbox_stat_q;
      trace_d        = trace_q;

      if (trap_valid) begin
         mepc_d         = trap_pc & 32'hFFFF_FFFC;
         mcause_d       = trap_cause;
         mtval_d        = trap_tval;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_valid) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (wr_en && csr.csr_addr == CSR_MSTATUS) begin
         mstatus_mie_d  = wval[3];
         mstatus_mpie_d = wval[7];
      end

      if (wr_en) begin
         case (csr.csr_addr)
            CSR_MIE:           mie_d       = wval & MIE_MASK;
            CSR_MTVEC:         mtvec_d     = {wval[31:2], 1'b0, wval[0]};
            CSR_MSCRATCH:      mscratch_d  = wval;
            CSR_MEPC:          mepc_d      = wval & 32'hFFFF_FFFC;
            CSR_MCAUSE:        mcause_d    = wval;
            CSR_MTVAL:         mtval_d     = wval;
            CSR_CP_MBOX_BASE:  mbox_base_d = wval;
            CSR_CP_TRACE_CTRL: trace_d     = wval[7:0];
            CSR_CP_MBOX_STATUS: mbox_stat_d = mbox_stat_q & ~csr.csr_operand[NUM_MBOX-1:0];
            default: ;
         endcase
      end

      mbox_stat_d = mbox_stat_d | mbox_set;
   end

   // Architectural state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mbox_base_q    <= '0;
         mbox_stat_q    <= '0;
         trace_q        <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mbox_base_q    <= mbox_base_d;
         mbox_stat_q    <= mbox_stat_d;
         trace_q        <= trace_d;
      end
   end

`ifdef MCU_CSR_WDOG_EN
   logic [31:0] wdog_q, wdog_d;
   logic [1:0]  wdog_ctrl_q, wdog_ctrl_d;
   logic        wdip_q, wdip_d;
   logic        wdog_expire_q, wdog_fire;
   logic        wdog_rst_req_q, wdog_rst_req_d;

   // Watchdog countdown: a kick overrides the decrement; expiry only on 1->0
   always_comb begin
      wdog_d         = wdog_q;
      wdog_fire      = 1'b0;
      wdog_ctrl_d    = wdog_ctrl_q;
      wdip_d         = wdip_q;
      if (wr_en && csr.csr_addr == CSR_CP_WDOG) begin
         wdog_d = wval;
      end else if (wdog_ctrl_q[0] && wdog_q != 32'd0) begin
         wdog_d    = wdog_q - 32'd1;
         wdog_fire = (wdog_q == 32'd1);
      end
      if (wr_en && csr.csr_addr == CSR_CP_WDOG_CTRL) begin
         wdog_ctrl_d = wval[1:0];
      end
      if (wr_en && csr.csr_addr == CSR_MIP) begin
         wdip_d = wval[16];
      end
      if (wdog_fire) begin
         wdip_d = 1'b1;
      end
      wdog_rst_req_d = wdog_rst_req_q | (wdog_fire & wdog_ctrl_q[1]);
   end

   // Watchdog state register; reset clears a countdown and a pending reset request at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q         <= '0;
         wdog_ctrl_q    <= '0;
         wdip_q         <= 1'b0;
         wdog_expire_q  <= 1'b0;
         wdog_rst_req_q <= 1'b0;
      end else begin
         wdog_q         <= wdog_d;
         wdog_ctrl_q    <= wdog_ctrl_d;
         wdip_q         <= wdip_d;
         wdog_expire_q  <= wdog_fire;
         wdog_rst_req_q <= wdog_rst_req_d;
      end
   end

   assign wdog_rd      = wdog_q;
   assign wdog_ctrl_rd = {30'b0, wdog_ctrl_q};
   assign wdip_rd      = wdip_q;
   assign wdog_expire  = wdog_expire_q;
   assign wdog_rst_req = wdog_rst_req_q;
`else
   assign wdog_rd      = '0;
   assign wdog_ctrl_rd = '0;
   assign wdip_rd      = 1'b0;
   assign wdog_expire  = 1'b0;
   assign wdog_rst_req = 1'b0;
`endif

   // Vectored mode only offsets for interrupts; exceptions go to the base
   always_comb begin
      trap_vector = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[0] && trap_cause[31]) begin
         trap_vector = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00};
      end
   end

   assign mret_pc     = mepc_q;
   assign irq_pending = mstatus_mie_q & (|(mip_rd & mie_q));
   assign mbox_base   = mbox_base_q;
   assign trace_ctrl  = trace_q;

endmodule
